// File: rtl/aux_xact.sv
// aux_xact: native AUX request/reply engine between the register block and a byte-level AUX PHY.
// Sends one-byte read/write requests, parses the reply and retries on DEFER, timeout or PHY error.
`timescale 1ns/1ps
module aux_xact #(
    parameter int TIMEOUT  = 40000,
    parameter int RETRYGAP = 5000,
    parameter int MAXRETRY = 7
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [19:0] auxaddr,
    input  logic [7:0]  auxwdata,
    input  logic        auxwr,
    input  logic        auxreq,
    output logic        auxack,
    output logic        auxerr,
    output logic [7:0]  auxrdata,
    output logic [7:0]  txdata,
    output logic        txvalid,
    output logic        txlast,
    input  logic        txready,
    input  logic [7:0]  rxdata,
    input  logic        rxvalid,
    input  logic        rxlast,
    input  logic        rxerr,
    output logic [2:0]  retries,
    output logic        busy
);
    localparam int CNTMAX = (TIMEOUT > RETRYGAP) ? TIMEOUT : RETRYGAP;
    localparam int CW = $clog2(CNTMAX + 1);
    localparam logic [CW-1:0] TMO_LOAD = CW'(TIMEOUT);
    localparam logic [CW-1:0] GAP_LOAD = CW'(RETRYGAP);
    localparam logic [2:0]    MAXR     = 3'(MAXRETRY);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SEND  = 3'd1,
        WAIT  = 3'd2,
        RECV  = 3'd3,
        GAP   = 3'd4,
        ACKED = 3'd5
    } state_t;

    state_t          state_r;
    logic [19:0]     addr_r;
    logic [7:0]      wdata_r;
    logic            wr_r;
    logic [2:0]      idx_r;
    logic [CW-1:0]   cnt_r;
    logic [3:0]      code_r;
    logic [7:0]      data_r;
    logic            have_data_r;

    logic [3:0]      code_s;
    logic            fail_s;
    logic            give_up_s;
    logic            done_s;
    logic            done_err_s;
    logic            done_rd_s;
    logic [7:0]      done_data_s;
    logic [2:0]      last_idx_s;

    // Request packet: {cmd, addr[19:16]}, addr[15:8], addr[7:0], length-1, then the write byte.
    function automatic logic [7:0] req_byte(input logic [2:0] idx, input logic wr,
                                            input logic [19:0] addr, input logic [7:0] wdata);
        logic [7:0] b;
        case (idx)
            3'd0:    b = {(wr ? 4'b1000 : 4'b1001), addr[19:16]};
            3'd1:    b = addr[15:8];
            3'd2:    b = addr[7:0];
            3'd3:    b = 8'h00;
            3'd4:    b = wdata;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    assign last_idx_s = wr_r ? 3'd4 : 3'd3;

    // Classify the current reply byte (or an expired timer) into retry or completion outcomes.
    always_comb begin
        code_s      = (state_r == WAIT) ? rxdata[7:4] : code_r;
        fail_s      = 1'b0;
        done_s      = 1'b0;
        done_err_s  = 1'b0;
        done_rd_s   = 1'b0;
        done_data_s = have_data_r ? data_r : rxdata;
        if ((state_r == WAIT || state_r == RECV) && rxvalid) begin
            if (rxerr) begin
                fail_s = 1'b1;
            end else if (rxlast) begin
                case (code_s)
                    4'b0000: begin
                        done_s = 1'b1;
                        if (wr_r) begin
                            done_err_s = 1'b0;
                        end else if (state_r == RECV) begin
                            done_rd_s = 1'b1;
                        end else begin
                            // read ACK that ends on its code byte carries no data
                            done_err_s = 1'b1;
                        end
                    end
                    4'b0001: begin
                        done_s     = 1'b1;
                        done_err_s = 1'b1;
                    end
                    4'b0010: fail_s = 1'b1;
                    default: begin
                        done_s     = 1'b1;
                        done_err_s = 1'b1;
                    end
                endcase
            end else begin
                fail_s = 1'b0;
            end
        end else if (state_r == WAIT && cnt_r == CW'(1)) begin
            fail_s = 1'b1;
        end else begin
            fail_s = 1'b0;
        end
        give_up_s = fail_s && (retries >= MAXR);
    end

    // Transaction sequencer driving every registered output.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r     <= IDLE;
            addr_r      <= 20'h00000;
            wdata_r     <= 8'h00;
            wr_r        <= 1'b0;
            idx_r       <= 3'd0;
            cnt_r       <= '0;
            code_r      <= 4'h0;
            data_r      <= 8'h00;
            have_data_r <= 1'b0;
            auxack      <= 1'b0;
            auxerr      <= 1'b0;
            auxrdata    <= 8'h00;
            txdata      <= 8'h00;
            txvalid     <= 1'b0;
            txlast      <= 1'b0;
            retries     <= 3'd0;
            busy        <= 1'b0;
        end else begin
            auxack <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (auxreq) begin
                        addr_r  <= auxaddr;
                        wdata_r <= auxwdata;
                        wr_r    <= auxwr;
                        retries <= 3'd0;
                        idx_r   <= 3'd0;
                        txdata  <= req_byte(3'd0, auxwr, auxaddr, auxwdata);
                        txvalid <= 1'b1;
                        txlast  <= 1'b0;
                        busy    <= 1'b1;
                        state_r <= SEND;
                    end
                end
                SEND: begin
                    if (txready) begin
                        if (txlast) begin
                            txvalid <= 1'b0;
                            txlast  <= 1'b0;
                            cnt_r   <= TMO_LOAD;
                            state_r <= WAIT;
                        end else begin
                            idx_r  <= idx_r + 3'd1;
                            txdata <= req_byte(idx_r + 3'd1, wr_r, addr_r, wdata_r);
                            txlast <= ((idx_r + 3'd1) == last_idx_s);
                        end
                    end
                end
                WAIT, RECV: begin
                    if (done_s || give_up_s) begin
                        auxack  <= 1'b1;
                        auxerr  <= give_up_s | done_err_s;
                        if (done_rd_s) begin
                            auxrdata <= done_data_s;
                        end
                        state_r <= ACKED;
                    end else if (fail_s) begin
                        retries <= retries + 3'd1;
                        cnt_r   <= GAP_LOAD;
                        state_r <= GAP;
                    end else if (state_r == WAIT) begin
                        if (rxvalid) begin
                            code_r      <= rxdata[7:4];
                            have_data_r <= 1'b0;
                            state_r     <= RECV;
                        end else begin
                            cnt_r <= cnt_r - CW'(1);
                        end
                    end else if (rxvalid && !have_data_r && !wr_r && code_r == 4'b0000) begin
                        data_r      <= rxdata;
                        have_data_r <= 1'b1;
                    end
                end
                GAP: begin
                    if (cnt_r == CW'(1)) begin
                        idx_r   <= 3'd0;
                        txdata  <= req_byte(3'd0, wr_r, addr_r, wdata_r);
                        txvalid <= 1'b1;
                        txlast  <= 1'b0;
                        state_r <= SEND;
                    end else begin
                        cnt_r <= cnt_r - CW'(1);
                    end
                end
                ACKED: begin
                    if (!auxreq) begin
                        busy    <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                default: begin
                    txvalid <= 1'b0;
                    txlast  <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_aux_xact.sv
// Randomized self-checking bench for aux_xact: a PHY stand-in replays scripted reply outcomes
// and a transaction-level model predicts bytes, timing, retries and status.
`timescale 1ns/1ps
module tb_aux_xact;
    localparam int T  = 100;
    localparam int G  = 10;
    localparam int MR = 7;
    localparam int O_OK = 0, O_NACK = 1, O_DEFER = 2, O_TMO = 3, O_RXERR = 4, O_SHORT = 5, O_OTHER = 6;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [19:0] auxaddr = 20'h0;
    logic [7:0]  auxwdata = 8'h0;
    logic        auxwr = 1'b0;
    logic        auxreq = 1'b0;
    logic        auxack, auxerr, txvalid, txlast, busy;
    logic [7:0]  auxrdata, txdata;
    logic [2:0]  retries;
    logic        txready = 1'b0;
    logic [7:0]  rxdata = 8'h0;
    logic        rxvalid = 1'b0, rxlast = 1'b0, rxerr = 1'b0;

    aux_xact #(.TIMEOUT(T), .RETRYGAP(G), .MAXRETRY(MR)) dut (
        .clk(clk), .rstn(rstn), .auxaddr(auxaddr), .auxwdata(auxwdata), .auxwr(auxwr),
        .auxreq(auxreq), .auxack(auxack), .auxerr(auxerr), .auxrdata(auxrdata),
        .txdata(txdata), .txvalid(txvalid), .txlast(txlast), .txready(txready),
        .rxdata(rxdata), .rxvalid(rxvalid), .rxlast(rxlast), .rxerr(rxerr),
        .retries(retries), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0, cyc = 0, ack_seen = 0, ack_exp = 0, hold_ovr = -1;
    logic [7:0] model_rd = 8'h00;
    int         script[8];
    logic [7:0] script_dat[8];
    int         script_dly[8];

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (auxack === 1'b1) ack_seen <= ack_seen + 1;

    initial begin
        #900000;
        $display("FAIL watchdog: run did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit is_retry(input int o);
        return (o == O_DEFER) || (o == O_TMO) || (o == O_RXERR);
    endfunction

    task automatic set_all(input int o);
        for (int k = 0; k <= MR; k++) begin
            script[k] = o;
            script_dat[k] = 8'h00;
            script_dly[k] = -1;
        end
    endtask

    task automatic run_xact(input logic wr, input logic [19:0] addr, input logic [7:0] wd);
        logic [7:0] eb[5];
        logic [7:0] rb[8];
        int nb, nrb, fin, oc, n, guard, t_tx, t_fail, d, e, hold;
        logic exp_err;
        logic [7:0] exp_rd;
        eb[0] = {(wr ? 4'b1000 : 4'b1001), addr[19:16]};
        eb[1] = addr[15:8];
        eb[2] = addr[7:0];
        eb[3] = 8'h00;
        eb[4] = wd;
        nb = wr ? 5 : 4;
        for (int k = 0; k <= MR; k++) if (wr && script[k] == O_SHORT) script[k] = O_OK;
        // the transaction ends at the first non-retryable outcome, or after MR resends
        fin = MR;
        for (int k = MR; k >= 0; k--) if (!is_retry(script[k])) fin = k;
        oc = script[fin];
        exp_err = (oc != O_OK);
        exp_rd = (oc == O_OK && !wr) ? script_dat[fin] : model_rd;

        auxaddr = addr; auxwdata = wd; auxwr = wr; auxreq = 1'b1;
        t_tx = cyc + 1;
        t_fail = 0;
        for (int a = 0; a <= fin; a++) begin
            guard = 0;
            while (txvalid !== 1'b1 && guard < 3 * T) begin
                if (a > 0 && cyc >= t_fail) begin
                    rxvalid = 1'($urandom_range(0, 1)); rxdata = 8'($urandom);
                    rxlast = 1'($urandom_range(0, 1)); rxerr = 1'b0;
                end
                tick(); guard++;
            end
            rxvalid = 1'b0; rxlast = 1'b0;
            check_val("tx_start_cycle", cyc, t_tx);
            check_val("retries_live", 32'(retries), a);
            check_val("busy_live", 32'(busy), 32'd1);
            n = 0; guard = 0;
            while (n < nb && guard < 200) begin
                txready = ($urandom_range(0, 2) != 0);
                check_val("txvalid", 32'(txvalid), 32'd1);
                check_val("txdata", 32'(txdata), 32'(eb[n]));
                check_val("txlast", 32'(txlast), 32'(n == nb - 1));
                if (txready) n++;
                tick(); guard++;
            end
            txready = 1'b0;
            check_val("tx_bytes", n, nb);
            check_val("txvalid_off", 32'(txvalid), 32'd0);
            oc = script[a];
            if (oc == O_TMO) begin
                t_fail = cyc + T;
            end else begin
                d = (script_dly[a] >= 0) ? script_dly[a] : $urandom_range(0, 15);
                nrb = 1;
                case (oc)
                    O_OK: begin
                        rb[0] = {4'h0, 4'($urandom)};
                        if (!wr) begin rb[1] = script_dat[a]; nrb = 2; end
                    end
                    O_NACK:  rb[0] = {4'h1, 4'($urandom)};
                    O_DEFER: rb[0] = {4'h2, 4'($urandom)};
                    O_OTHER: rb[0] = {4'($urandom_range(3, 15)), 4'($urandom)};
                    O_SHORT: rb[0] = {4'h0, 4'($urandom)};
                    default: rb[0] = 8'($urandom);
                endcase
                if (oc == O_OK || oc == O_NACK || oc == O_OTHER) begin
                    e = $urandom_range(0, 2);
                    for (int i = 0; i < e; i++) begin rb[nrb] = 8'($urandom); nrb++; end
                end
                repeat (d) tick();
                for (int i = 0; i < nrb; i++) begin
                    rxvalid = 1'b1; rxdata = rb[i]; rxlast = (i == nrb - 1); rxerr = (oc == O_RXERR);
                    tick();
                    rxvalid = 1'b0; rxlast = 1'b0; rxerr = 1'b0;
                    if (i < nrb - 1 && $urandom_range(0, 1) == 1) tick();
                end
                t_fail = cyc;
            end
            t_tx = t_fail + G;
        end

        guard = 0;
        while (auxack !== 1'b1 && guard < 3 * T) begin tick(); guard++; end
        check_val("ack_cycle", cyc, t_fail);
        check_val("auxerr", 32'(auxerr), 32'(exp_err));
        check_val("auxrdata", 32'(auxrdata), 32'(exp_rd));
        check_val("retries", 32'(retries), fin);
        model_rd = exp_rd;
        ack_exp++;
        hold = (hold_ovr >= 0) ? hold_ovr : $urandom_range(0, 5);
        tick();
        check_val("ack_pulse", 32'(auxack), 32'd0);
        for (int i = 0; i < hold; i++) begin
            check_val("held_no_tx", 32'(txvalid), 32'd0);
            check_val("held_no_ack", 32'(auxack), 32'd0);
            tick();
        end
        auxreq = 1'b0;
        tick();
        check_val("busy_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        int r;
        repeat (3) tick();
        check_val("rst_auxack", 32'(auxack), 32'd0);
        check_val("rst_auxerr", 32'(auxerr), 32'd0);
        check_val("rst_txvalid", 32'(txvalid), 32'd0);
        check_val("rst_txlast", 32'(txlast), 32'd0);
        check_val("rst_auxrdata", 32'(auxrdata), 32'd0);
        check_val("rst_txdata", 32'(txdata), 32'd0);
        check_val("rst_retries", 32'(retries), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        rstn = 1'b1;
        tick();

        set_all(O_OK); script_dat[0] = 8'h84; hold_ovr = 5;
        run_xact(1'b0, 20'h00101, 8'h00);
        hold_ovr = -1;
        set_all(O_OK);
        run_xact(1'b1, 20'hF0203, 8'h5A);
        set_all(O_OK); script[0] = O_DEFER; script[1] = O_DEFER; script_dat[2] = 8'h11;
        run_xact(1'b0, 20'h00200, 8'h00);
        set_all(O_TMO);
        run_xact(1'b0, 20'h12345, 8'h00);
        set_all(O_NACK);
        run_xact(1'b0, 20'h00300, 8'h00);
        set_all(O_SHORT);
        run_xact(1'b0, 20'h00400, 8'h00);
        set_all(O_OK); script[0] = O_RXERR; script_dat[1] = 8'h3C;
        run_xact(1'b0, 20'h00500, 8'h00);
        set_all(O_OK); script_dly[0] = T - 1; script_dat[0] = 8'hA5;
        run_xact(1'b0, 20'h00600, 8'h00);
        set_all(O_OTHER);
        run_xact(1'b1, 20'h00700, 8'hC3);

        // reset while the request is stalled in the PHY
        auxaddr = 20'h00800; auxwr = 1'b0; auxreq = 1'b1; txready = 1'b0;
        tick(); tick();
        check_val("pre_rst_txvalid", 32'(txvalid), 32'd1);
        rstn = 1'b0;
        #1;
        check_val("midrst_txvalid", 32'(txvalid), 32'd0);
        check_val("midrst_busy", 32'(busy), 32'd0);
        auxreq = 1'b0;
        tick(); tick();
        rstn = 1'b1;
        tick();
        check_val("post_rst_busy", 32'(busy), 32'd0);
        check_val("post_rst_rdata", 32'(auxrdata), 32'd0);
        model_rd = 8'h00;

        for (int t = 0; t < 40; t++) begin
            for (int k = 0; k <= MR; k++) begin
                r = $urandom_range(0, 99);
                script[k] = (r < 35) ? O_OK : (r < 55) ? O_DEFER : (r < 63) ? O_TMO :
                            (r < 75) ? O_RXERR : (r < 85) ? O_NACK : (r < 93) ? O_SHORT : O_OTHER;
                script_dat[k] = 8'($urandom);
                script_dly[k] = -1;
            end
            run_xact(1'($urandom_range(0, 1)), 20'($urandom), 8'($urandom));
            repeat ($urandom_range(0, 3)) tick();
        end

        tick();
        check_val("ack_count", ack_seen, ack_exp);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
